// File: rtl/dpll_lock_sequencer.sv
// rtl/dpll_lock_sequencer.sv - DPLL lock acquisition, verification and tracking sequencer
module dpll_lock_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned ACQ_TIMEOUT   = 400000,
    parameter int unsigned VERIFY_CYCLES = 20000,
    parameter int unsigned LOSS_CYCLES   = 4000,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter logic [7:0]  QUAL_MIN      = 8'h80
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] req_rate,
    input  logic       req_rpm_360,
    input  logic       pll_locked,
    input  logic [7:0] lock_quality,
    output logic       pll_enable,
    output logic [1:0] pll_data_rate,
    output logic       pll_rpm_360,
    output logic       busy,
    output logic       lock_ok,
    output logic       fail,
    output logic       lost_lock,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_TRACK   = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
    localparam logic [23:0] ACQ_LAST    = 24'(ACQ_TIMEOUT - 1);
    localparam logic [23:0] VERIFY_LAST = 24'(VERIFY_CYCLES - 1);
    localparam logic [23:0] LOSS_LAST   = 24'(LOSS_CYCLES - 1);
    localparam logic [1:0]  RETRY_MAX   = 2'(MAX_RETRIES);

    state_t      state_q, state_n;
    logic [23:0] timer_q, timer_n;
    logic [23:0] loss_ctr_q, loss_ctr_n;
    logic [1:0]  retry_n, rate_n;
    logic [7:0]  loss_cnt_n;
    logic        rpm_n, fail_n, lost_n, restart;
    logic        enable_n, busy_n, lock_ok_n;

    always_comb begin
        state_n    = state_q;
        timer_n    = timer_q + 24'd1;
        loss_ctr_n = '0;
        retry_n    = retry_cnt;
        loss_cnt_n = loss_cnt;
        rate_n     = pll_data_rate;
        rpm_n      = pll_rpm_360;
        fail_n     = fail;
        lost_n     = 1'b0;
        restart    = 1'b0;

        if (stop) begin
            state_n = ST_IDLE;
        end else if (start) begin
            state_n = ST_SETTLE;
            restart = 1'b1;
            rate_n  = req_rate;
            rpm_n   = req_rpm_360;
            retry_n = '0;
            fail_n  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_SETTLE:
                    if (timer_q == SETTLE_LAST) state_n = ST_ACQUIRE;
                ST_ACQUIRE:
                    if (pll_locked && (lock_quality >= QUAL_MIN)) begin
                        state_n = ST_VERIFY;
                    end else if (timer_q == ACQ_LAST) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state_n = ST_FAIL;
                            fail_n  = 1'b1;
                        end else begin
                            state_n = ST_SETTLE;
                            retry_n = retry_cnt + 2'd1;
                        end
                    end
                ST_VERIFY:
                    if (!pll_locked)                state_n = ST_ACQUIRE;
                    else if (timer_q == VERIFY_LAST) state_n = ST_TRACK;
                ST_TRACK:
                    // Loss counter runs only on consecutive unlocked cycles.
                    if (!pll_locked) begin
                        if (loss_ctr_q == LOSS_LAST) begin
                            state_n = ST_ACQUIRE;
                            lost_n  = 1'b1;
                            retry_n = '0;
                            if (loss_cnt != 8'hFF) loss_cnt_n = loss_cnt + 8'd1;
                        end else begin
                            loss_ctr_n = loss_ctr_q + 24'd1;
                        end
                    end
                ST_FAIL: ;
                default: state_n = ST_IDLE;
            endcase
        end

        if (restart || (state_n != state_q)) timer_n = '0;

        enable_n  = (state_n == ST_ACQUIRE) || (state_n == ST_VERIFY) || (state_n == ST_TRACK);
        busy_n    = (state_n == ST_SETTLE) || (state_n == ST_ACQUIRE) || (state_n == ST_VERIFY);
        lock_ok_n = (state_n == ST_TRACK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            loss_ctr_q    <= '0;
            retry_cnt     <= '0;
            loss_cnt      <= '0;
            pll_enable    <= 1'b0;
            busy          <= 1'b0;
            lock_ok       <= 1'b0;
            fail          <= 1'b0;
            lost_lock     <= 1'b0;
            pll_data_rate <= 2'b00;
            pll_rpm_360   <= 1'b0;
        end else begin
            state_q       <= state_n;
            timer_q       <= timer_n;
            loss_ctr_q    <= loss_ctr_n;
            retry_cnt     <= retry_n;
            loss_cnt      <= loss_cnt_n;
            pll_enable    <= enable_n;
            busy          <= busy_n;
            lock_ok       <= lock_ok_n;
            fail          <= fail_n;
            lost_lock     <= lost_n;
            pll_data_rate <= rate_n;
            pll_rpm_360   <= rpm_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_dpll_lock_sequencer.sv
// tb/tb_dpll_lock_sequencer.sv - scoreboard bench for dpll_lock_sequencer state transitions
module tb_dpll_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0;
    logic [1:0] req_rate = 2'b00;
    logic       req_rpm_360 = 1'b0;
    logic       pll_locked = 1'b0;
    logic [7:0] lock_quality = 8'h00;
    logic       pll_enable, pll_rpm_360, busy, lock_ok, fail, lost_lock;
    logic [1:0] pll_data_rate, retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_passed = 0;
    int cyc = 0;
    logic [63:0] exp_q[$];
    logic [2:0]  prev_state = 3'd0;

    dpll_lock_sequencer #(
        .SETTLE_CYCLES(4), .ACQ_TIMEOUT(100), .VERIFY_CYCLES(10),
        .LOSS_CYCLES(5), .MAX_RETRIES(2), .QUAL_MIN(8'h80)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .req_rate(req_rate), .req_rpm_360(req_rpm_360),
        .pll_locked(pll_locked), .lock_quality(lock_quality),
        .pll_enable(pll_enable), .pll_data_rate(pll_data_rate), .pll_rpm_360(pll_rpm_360),
        .busy(busy), .lock_ok(lock_ok), .fail(fail), .lost_lock(lost_lock),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pk(int at, logic [2:0] st, logic en, logic bs, logic ok,
                                       logic fl, logic lo, logic [1:0] rt, logic [7:0] ls,
                                       logic [1:0] rate, logic rpm);
        return {11'd0, 32'(at), st, en, bs, ok, fl, lo, rt, ls, rate, rpm};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic ex(int at, logic [2:0] st, logic en, logic bs, logic ok, logic fl, logic lo,
                      logic [1:0] rt, logic [7:0] ls, logic [1:0] rate, logic rpm);
        exp_q.push_back(pk(at, st, en, bs, ok, fl, lo, rt, ls, rate, rpm));
    endtask

    // Monitor: every state change (or lost_lock pulse) is one observed response.
    always @(negedge clk) begin
        if ((state != prev_state) || lost_lock) begin
            if (exp_q.size() == 0)
                check("unexpected_event", pk(cyc, state, pll_enable, busy, lock_ok, fail, lost_lock,
                      retry_cnt, loss_cnt, pll_data_rate, pll_rpm_360), 64'hFFFF_FFFF_FFFF_FFFF);
            else
                check("event", pk(cyc, state, pll_enable, busy, lock_ok, fail, lost_lock,
                      retry_cnt, loss_cnt, pll_data_rate, pll_rpm_360), exp_q.pop_front());
        end
        prev_state = state;
    end

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_start(logic [1:0] rate, logic rpm, output int s);
        req_rate = rate;
        req_rpm_360 = rpm;
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int s, s2, s3, s4;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_state", {state, pll_enable, busy, lock_ok, fail, lost_lock, retry_cnt,
              loss_cnt, pll_data_rate, pll_rpm_360}, '0);

        // One timeout retry, then lock, verify dropout on VERIFY cycle 6, re-verify, track
        pll_locked = 1'b1;
        lock_quality = 8'h7F;
        wait_until(cyc + 2);
        s = cyc;
        ex(s+1,   1, 0, 1, 0, 0, 0, 0, 0, 2, 1);
        ex(s+5,   2, 1, 1, 0, 0, 0, 0, 0, 2, 1);
        ex(s+105, 1, 0, 1, 0, 0, 0, 1, 0, 2, 1);
        ex(s+109, 2, 1, 1, 0, 0, 0, 1, 0, 2, 1);
        ex(s+116, 3, 1, 1, 0, 0, 0, 1, 0, 2, 1);
        ex(s+123, 2, 1, 1, 0, 0, 0, 1, 0, 2, 1);
        ex(s+124, 3, 1, 1, 0, 0, 0, 1, 0, 2, 1);
        ex(s+134, 4, 1, 0, 1, 0, 0, 1, 0, 2, 1);
        do_start(2'b10, 1'b1, s);
        wait_until(s+110); req_rate = 2'b01; req_rpm_360 = 1'b0;
        wait_until(s+115); lock_quality = 8'hC0;
        wait_until(s+122); pll_locked = 1'b0;
        wait_until(s+123); pll_locked = 1'b1;

        // Loss in TRACK: 4 low cycles ignored, 5 low cycles declare loss
        wait_until(s+140); pll_locked = 1'b0;
        wait_until(s+144); pll_locked = 1'b1;
        ex(s+155, 2, 1, 1, 0, 0, 1, 0, 1, 2, 1);
        ex(s+156, 3, 1, 1, 0, 0, 0, 0, 1, 2, 1);
        ex(s+166, 4, 1, 0, 1, 0, 0, 0, 1, 2, 1);
        wait_until(s+150); pll_locked = 1'b0;
        wait_until(s+155); pll_locked = 1'b1;

        // Quality gate: locked but quality 7F, retries exhausted -> FAIL
        wait_until(s+175);
        lock_quality = 8'h7F;
        s2 = cyc;
        ex(s2+1,   1, 0, 1, 0, 0, 0, 0, 1, 3, 0);
        ex(s2+5,   2, 1, 1, 0, 0, 0, 0, 1, 3, 0);
        ex(s2+105, 1, 0, 1, 0, 0, 0, 1, 1, 3, 0);
        ex(s2+109, 2, 1, 1, 0, 0, 0, 1, 1, 3, 0);
        ex(s2+209, 1, 0, 1, 0, 0, 0, 2, 1, 3, 0);
        ex(s2+213, 2, 1, 1, 0, 0, 0, 2, 1, 3, 0);
        ex(s2+313, 5, 0, 0, 0, 1, 0, 2, 1, 3, 0);
        do_start(2'b11, 1'b0, s2);

        // Stop from FAIL keeps fail; start clears it; stop+start mid-ACQUIRE -> IDLE
        wait_until(s2+320);
        ex(s2+321, 0, 0, 0, 0, 1, 0, 2, 1, 3, 0);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        wait_until(s2+325);
        s3 = cyc;
        ex(s3+1,  1, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        ex(s3+5,  2, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        ex(s3+21, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        do_start(2'b00, 1'b1, s3);
        wait_until(s3+20);
        req_rate = 2'b11; req_rpm_360 = 1'b0;
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;

        // Restart at rate 01 with quality exactly at threshold
        wait_until(s3+25);
        lock_quality = 8'h80;
        pll_locked = 1'b1;
        s4 = cyc;
        ex(s4+1,  1, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        ex(s4+5,  2, 1, 1, 0, 0, 0, 0, 1, 1, 0);
        ex(s4+6,  3, 1, 1, 0, 0, 0, 0, 1, 1, 0);
        ex(s4+16, 4, 1, 0, 1, 0, 0, 0, 1, 1, 0);
        do_start(2'b01, 1'b0, s4);

        // Asynchronous reset while tracking
        wait_until(s4+20);
        ex(s4+21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1 check("async_reset_outputs", {52'd0, pll_enable, lock_ok, loss_cnt, state}, '0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/dpll_lock_sequencer.md
DPLL_LOCK_SEQUENCER -- requirements
Module: dpll_lock_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- SETTLE_CYCLES, 64: cycles digital_pll is held disabled before each acquire attempt.
- ACQ_TIMEOUT, 400000: acquire window in cycles (2 ms at 200 MHz).
- VERIFY_CYCLES, 20000: cycles pll_locked must stay high continuously to confirm lock.
- LOSS_CYCLES, 4000: consecutive unlocked cycles in TRACK that declare loss of lock.
- MAX_RETRIES, 3: acquire retries allowed after the first attempt.
- QUAL_MIN, 8'h80: minimum lock_quality accepted for lock.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: 200 MHz clock.
- reset_n, in, 1: asynchronous active-low reset.
- start, in, 1: pulse; begin or restart the lock sequence.
- stop, in, 1: pulse; abort and disable the PLL.
- req_rate, in, 2: requested data rate.
- req_rpm_360, in, 1: requested spindle-speed mode.
- pll_locked, in, 1: lock status from the DPLL.
- lock_quality, in, 8: quality figure from the DPLL.
- pll_enable, out, 1: DPLL enable.
- pll_data_rate, out, 2: rate applied to the DPLL.
- pll_rpm_360, out, 1: rpm mode applied to the DPLL.
- busy, out, 1: sequence in progress.
- lock_ok, out, 1: lock confirmed.
- fail, out, 1: retries exhausted.
- lost_lock, out, 1: one-cycle pulse on loss of lock in TRACK.
- retry_cnt, out, 2: retries used in the current sequence.
- loss_cnt, out, 8: saturating count of loss events.
- state, out, 3: FSM state.

Function
REQ-003 State encoding: IDLE=0, SETTLE=1, ACQUIRE=2, VERIFY=3, TRACK=4, FAIL=5; the encodings 6 and 7 shall return to IDLE on the next cycle.
REQ-004 A single 24-bit cycle timer shall serve all states; it clears to 0 on every state transition and increments by 1 per cycle otherwise.
REQ-005 stop shall force IDLE on the next clock from any state; stop has priority over start when both are asserted in the same cycle.
REQ-006 start from any state (stop low) shall:
- latch req_rate into pll_data_rate and req_rpm_360 into pll_rpm_360;
- clear retry_cnt, fail and lock_ok;
- enter SETTLE on the next clock.
Mid-sequence start is a full restart.
REQ-007 IDLE: pll_enable=0, busy=0, lock_ok=0; fail is held at its current value.
REQ-008 SETTLE: pll_enable=0, busy=1; when timer reaches SETTLE_CYCLES-1, go to ACQUIRE.
REQ-009 ACQUIRE: pll_enable=1, busy=1. On a given cycle:
- if pll_locked=1 and lock_quality>=QUAL_MIN, go to VERIFY;
- otherwise, if timer reaches ACQ_TIMEOUT-1 and retry_cnt==MAX_RETRIES, go to FAIL;
- otherwise, if timer reaches ACQ_TIMEOUT-1, increment retry_cnt and go to SETTLE.
Lock detection wins over timeout in the same cycle.
REQ-010 VERIFY: pll_enable=1. If pll_locked=0 on any cycle, go to ACQUIRE with a fresh timer and retry_cnt unchanged. When timer reaches VERIFY_CYCLES-1 with pll_locked=1, go to TRACK.
REQ-011 TRACK: pll_enable=1, lock_ok=1, busy=0.
- A counter counts consecutive cycles with pll_locked=0 and clears on any cycle with pll_locked=1.
- When the counter reaches LOSS_CYCLES, pulse lost_lock for 1 cycle, increment loss_cnt (saturating at 255), clear retry_cnt, clear lock_ok, and go to ACQUIRE.
REQ-012 FAIL: pll_enable=0, busy=0, fail=1; the FSM stays in FAIL until start or stop.
REQ-013 All outputs shall be registered; output changes appear on the clock edge that enters the new state (one-cycle latency from the qualifying input).
REQ-014 pll_data_rate and pll_rpm_360 shall change only on start; changes on req_rate or req_rpm_360 are ignored at all other times.
REQ-015 retry_cnt shall never exceed MAX_RETRIES; loss_cnt shall never wrap.

Reset
REQ-016 On reset_n low, asynchronously set:
- state=IDLE;
- timer, retry_cnt, loss_cnt and the loss counter to 0;
- pll_enable, busy, lock_ok, fail and lost_lock to 0;
- pll_data_rate=2'b00 and pll_rpm_360=0.
Release of reset_n is synchronous to clk.
REQ-017 Assertion of reset_n mid-sequence shall drop pll_enable immediately, without waiting for a clock edge.

Verification (bench overrides: SETTLE=4, ACQ_TIMEOUT=100, VERIFY=10, LOSS=5, MAX_RETRIES=2, QUAL_MIN=8'h80)
REQ-018 The bench shall cover the following directed scenarios:
- Nominal lock: start with req_rate=2'b10; pll_locked=1 and quality=8'hC0 from cycle 10 -> pll_enable rises 4 cycles after SETTLE entry, VERIFY, TRACK after 10 cycles, lock_ok=1, pll_data_rate=2'b10.
- Quality gate and retries: pll_locked=1 with quality=8'h7F throughout -> two SETTLE/ACQUIRE retries, retry_cnt=2, then FAIL with fail=1 and pll_enable=0 after 3x100 acquire cycles.
- Verify dropout: pll_locked drops for 1 cycle on VERIFY cycle 6 -> return to ACQUIRE, retry_cnt unchanged, re-verify, then TRACK.
- Loss in TRACK: pll_locked low for 4 cycles -> no action; low for 5 cycles -> one lost_lock pulse, loss_cnt=1, state=ACQUIRE.
- Stop and start together mid-ACQUIRE -> IDLE next cycle, pll_enable=0; a later start with req_rate=2'b01 -> SETTLE, pll_data_rate=2'b01, fail cleared.
- reset_n asserted in TRACK -> pll_enable=0 immediately, all outputs at reset values, loss_cnt=0.
